// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared state encoding and default word width for the
//               bit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : bit_serializer_pkg

`default_nettype wire

// File: rtl/ser_shift_reg.sv
// ============================================================================
// Module      : ser_shift_reg
// Description : Parallel-load shift register with bit counter; presents one
//               registered bit per cycle and flags the last bit of each word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_shift_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] w_load_ord;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_valid;
    logic             r_last;

    // The shifter always emits from the top bit, so LSB-first words are
    // mirrored on load.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_ord = i_load_data;
        end else begin : g_lsb_first
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
                assign w_load_ord[gi] = i_load_data[WIDTH-1-gi];
            end
        end
    endgenerate

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_shreg <= w_load_ord;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (r_valid && !r_last) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_cnt   <= w_cnt_inc;
            r_last  <= (w_cnt_inc == C_LAST_IDX);
        end else begin
            // Clearing the shifter keeps ser_out low whenever no bit is valid.
            r_shreg <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_ser_out   = r_shreg[WIDTH-1];
    assign o_ser_valid = r_valid;
    assign o_word_done = r_last;

endmodule : ser_shift_reg

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module      : bit_serializer
// Description : Word-to-bit serializer with one-deep hold register giving
//               gap-free back-to-back words; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             w_hold_full_nxt;
    logic             w_hold_wr;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_last;
    logic             r_busy;

    assign w_accept = data_valid & ~r_hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_busy      <= (w_state_nxt == SHIFT) | w_hold_full_nxt;
            if (w_hold_wr) begin
                r_hold <= data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_load_data     = r_hold;
        w_hold_wr       = 1'b0;
        w_hold_full_nxt = r_hold_full;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = data_in;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Refill on the last-bit edge so the next word starts
                    // without an idle cycle; an empty hold lets data_in bypass.
                    if (r_hold_full) begin
                        w_load          = 1'b1;
                        w_load_data     = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_load      = 1'b1;
                        w_load_data = data_in;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_accept) begin
                    w_hold_wr       = 1'b1;
                    w_hold_full_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser_shift_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .o_ser_out   (ser_out),
        .o_ser_valid (ser_valid),
        .o_word_done (w_last)
    );

    assign word_done  = w_last;
    assign data_ready = ~r_hold_full;
    assign busy       = r_busy;

endmodule : bit_serializer

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer (MSB- and
//               LSB-first instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       word_done;
    logic       busy;

    logic [7:0] l_data_in;
    logic       l_data_valid;
    logic       l_data_ready;
    logic       l_ser_out;
    logic       l_ser_valid;
    logic       l_word_done;
    logic       l_busy;

    int n_vec;
    int n_err;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (l_data_in),
        .data_valid (l_data_valid),
        .data_ready (l_data_ready),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .word_done  (l_word_done),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({ser_out, ser_valid, word_done, busy, data_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_msb: got {out,valid,done,busy,ready}=%b want 00001",
                     {ser_out, ser_valid, word_done, busy, data_ready});
        end
        n_vec++;
        if ({l_ser_out, l_ser_valid, l_word_done, l_busy, l_data_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_lsb: got {out,valid,done,busy,ready}=%b want 00001",
                     {l_ser_out, l_ser_valid, l_word_done, l_busy, l_data_ready});
        end
        // Release and accept on the very first edge afterwards.
        rst        = 1'b0;
        data_in    = 8'hC3;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        n_vec++;
        if ({ser_valid, ser_out, busy} !== 3'b111) begin
            n_err++;
            $display("FAIL first_accept: got {valid,out,busy}=%b want 111",
                     {ser_valid, ser_out, busy});
        end
        repeat (8) @(negedge clk);
        n_vec++;
        if ({ser_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL first_drain: got {valid,busy}=%b want 00", {ser_valid, busy});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w          = 8'hB0;
        data_in    = w;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'h00;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({ser_valid, ser_out, word_done} !== {1'b1, w[7-k], (k == 7)}) begin
                n_err++;
                $display("FAIL single_bit%0d: got {valid,out,done}=%b want %b",
                         k, {ser_valid, ser_out, word_done}, {1'b1, w[7-k], (k == 7)});
            end
            @(negedge clk);
        end
        n_vec++;
        if ({ser_valid, ser_out, word_done, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL single_idle: got {valid,out,done,busy}=%b want 0000",
                     {ser_valid, ser_out, word_done, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        logic        exp_rdy;
        s          = 16'hB06C;
        data_in    = 8'hB0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_rdy = (k == 0) || (k >= 8);
            n_vec++;
            if ({ser_valid, ser_out, word_done, data_ready} !==
                {1'b1, s[15-k], (k == 7) || (k == 15), exp_rdy}) begin
                n_err++;
                $display("FAIL b2b_bit%0d: got {valid,out,done,ready}=%b want %b",
                         k, {ser_valid, ser_out, word_done, data_ready},
                         {1'b1, s[15-k], (k == 7) || (k == 15), exp_rdy});
            end
            if (k == 0) begin
                data_in    = 8'h6C;
                data_valid = 1'b1;
            end else if (k == 1) begin
                data_in    = 8'h00;
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if ({ser_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_idle: got {valid,busy}=%b want 00", {ser_valid, busy});
        end
    endtask

    task automatic test_bypass();
        logic [15:0] s;
        s          = 16'hB0FF;
        data_in    = 8'hB0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if ({ser_valid, ser_out, word_done, data_ready} !==
                {1'b1, s[15-k], (k == 7) || (k == 15), 1'b1}) begin
                n_err++;
                $display("FAIL bypass_bit%0d: got {valid,out,done,ready}=%b want %b",
                         k, {ser_valid, ser_out, word_done, data_ready},
                         {1'b1, s[15-k], (k == 7) || (k == 15), 1'b1});
            end
            if (k == 7) begin
                data_in    = 8'hFF;
                data_valid = 1'b1;
            end else if (k == 8) begin
                data_in    = 8'h00;
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if ({ser_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL bypass_idle: got {valid,busy}=%b want 00", {ser_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        data_in    = 8'hA5;
        data_valid = 1'b1;
        @(negedge clk);
        data_in    = 8'h6C;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        // Third bit of A5 (MSB first) is 1, with 6C sitting in the hold register.
        n_vec++;
        if ({ser_valid, ser_out, busy, data_ready} !== 4'b1110) begin
            n_err++;
            $display("FAIL rstmid_pre: got {valid,out,busy,ready}=%b want 1110",
                     {ser_valid, ser_out, busy, data_ready});
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ser_out, ser_valid, word_done, busy, data_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL rstmid_async: got {out,valid,done,busy,ready}=%b want 00001",
                     {ser_out, ser_valid, word_done, busy, data_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if ({ser_valid, ser_out, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL rstmid_quiet%0d: got {valid,out,busy}=%b want 000",
                         i, {ser_valid, ser_out, busy});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w0;
        logic [7:0] w1;
        logic       exp_bit;
        logic       exp_rdy;
        w0           = 8'h0D;
        w1           = 8'h81;
        l_data_in    = w0;
        l_data_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            exp_bit = (k < 8) ? w0[k] : w1[k-8];
            exp_rdy = (k == 0) || (k >= 8);
            n_vec++;
            if ({l_ser_valid, l_ser_out, l_word_done, l_data_ready} !==
                {1'b1, exp_bit, (k == 7) || (k == 15), exp_rdy}) begin
                n_err++;
                $display("FAIL lsb_bit%0d: got {valid,out,done,ready}=%b want %b",
                         k, {l_ser_valid, l_ser_out, l_word_done, l_data_ready},
                         {1'b1, exp_bit, (k == 7) || (k == 15), exp_rdy});
            end
            // Valid stays high throughout; only the word offered while ready=1 may land.
            if (k == 0) begin
                l_data_in = w1;
            end else if (k == 1) begin
                l_data_in = 8'hFF;
            end else if (k == 8) begin
                l_data_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if ({l_ser_valid, l_ser_out, l_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL lsb_no_extra: got {valid,out,busy}=%b want 000",
                     {l_ser_valid, l_ser_out, l_busy});
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        data_in      = 8'h00;
        data_valid   = 1'b0;
        l_data_in    = 8'h00;
        l_data_valid = 1'b0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        test_lsb_first();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bit_serializer

`default_nettype wire
